// File: rtl/queue_pkg.sv
// Shared types and constants for the 8-entry byte queue and its drain controller.
package queue_pkg;

    localparam int DATA_W      = 8;
    localparam int LEN_W       = 4;
    localparam int QUEUE_DEPTH = 8;

    typedef logic [DATA_W-1:0] byte_t;
    typedef logic [LEN_W-1:0]  len_t;

    typedef enum logic [1:0] {
        IDLE,
        DEQ,
        CAPT,
        HOLD
    } drain_state_t;

    // An occupancy above the physical depth means the queue is misbehaving.
    function automatic logic len_is_illegal(input len_t len);
        return len > len_t'(QUEUE_DEPTH);
    endfunction

endpackage

// File: rtl/queue_drain_ctrl_rate_tick_gen.sv
// Drain-rate tick generator: one-cycle tick every TICK_DIV clocks (every cycle when TICK_DIV=1).
module rate_tick_gen #(
    parameter int TICK_DIV = 10
) (
    input  logic clock10mhz,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // Free-running 0..TICK_DIV-1 counter; tick marks the last count of each period.
    always_ff @(posedge clock10mhz or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/queue_drain_ctrl.sv
// Queue drain controller: pulls one byte at a time from the byte queue at a
// programmable rate and hands it downstream on a valid/ready handshake.
// Optional running XOR checksum of accepted bytes: define QUEUE_DRAIN_CHECKSUM_EN.
module queue_drain_ctrl
    import queue_pkg::*;
#(
    parameter int TICK_DIV = 10,
    parameter int CNT_W    = 16
) (
    input  logic              clock10mhz,
    input  logic              reset,
    input  logic [LEN_W-1:0]  len_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              dequeue_out,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [CNT_W-1:0]  byte_count_out,
    output logic              protocol_err_out,
    output logic [DATA_W-1:0] checksum_out
);

    drain_state_t state;
    drain_state_t next_state;
    logic         tick;
    logic         tick_pending;
    logic         start_deq;
    logic         capture;
    logic         transfer;

    rate_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock10mhz (clock10mhz),
        .reset      (reset),
        .tick       (tick)
    );

    // State register for the drain sequencer.
    always_ff @(posedge clock10mhz or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Sequencer: one dequeue, one capture, then hold until the byte is taken.
    always_comb begin
        next_state  = state;
        dequeue_out = 1'b0;
        start_deq   = 1'b0;
        capture     = 1'b0;
        transfer    = 1'b0;
        case (state)
            IDLE: begin
                if ((tick || tick_pending) && (len_in != '0)) begin
                    next_state = DEQ;
                    start_deq  = 1'b1;
                end
            end
            DEQ: begin
                dequeue_out = 1'b1;
                next_state  = CAPT;
            end
            CAPT: begin
                capture    = 1'b1;
                next_state = HOLD;
            end
            HOLD: begin
                if (valid_out && ready_in) begin
                    transfer   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Remember one drain opportunity until it is used; extra ticks merge into it.
    always_ff @(posedge clock10mhz or posedge reset) begin
        if (reset) begin
            tick_pending <= 1'b0;
        end else if (start_deq) begin
            tick_pending <= 1'b0;
        end else if (tick) begin
            tick_pending <= 1'b1;
        end
    end

    // Output byte register and its valid flag for the downstream handshake.
    always_ff @(posedge clock10mhz or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else if (capture) begin
            data_out  <= data_in;
            valid_out <= 1'b1;
        end else if (transfer) begin
            valid_out <= 1'b0;
        end
    end

    // Count accepted transfers; wraps silently.
    always_ff @(posedge clock10mhz or posedge reset) begin
        if (reset) begin
            byte_count_out <= '0;
        end else if (transfer) begin
            byte_count_out <= byte_count_out + CNT_W'(1);
        end
    end

    // Sticky flag for an occupancy the queue can never legally report.
    always_ff @(posedge clock10mhz or posedge reset) begin
        if (reset) begin
            protocol_err_out <= 1'b0;
        end else if (len_is_illegal(len_in)) begin
            protocol_err_out <= 1'b1;
        end
    end

`ifdef QUEUE_DRAIN_CHECKSUM_EN
    // Fold every accepted byte into the running XOR checksum.
    always_ff @(posedge clock10mhz or posedge reset) begin
        if (reset) begin
            checksum_out <= '0;
        end else if (transfer) begin
            checksum_out <= checksum_out ^ data_out;
        end
    end
`else
    assign checksum_out = '0;
`endif

endmodule

// File: tb/tb_queue_drain_ctrl.sv
// Self-checking bench for queue_drain_ctrl: a simple queue model feeds the DUT,
// a scoreboard holds the bytes expected downstream in order.
module tb_queue_drain_ctrl;

    logic        clock10mhz = 1'b0;
    logic        reset;
    logic [3:0]  len_in;
    logic [7:0]  data_in;
    logic        dequeue_out;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        ready_in;
    logic [15:0] byte_count_out;
    logic        protocol_err_out;
    logic [7:0]  checksum_out;

    queue_drain_ctrl #(
        .TICK_DIV (10),
        .CNT_W    (16)
    ) dut (
        .clock10mhz       (clock10mhz),
        .reset            (reset),
        .len_in           (len_in),
        .data_in          (data_in),
        .dequeue_out      (dequeue_out),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .ready_in         (ready_in),
        .byte_count_out   (byte_count_out),
        .protocol_err_out (protocol_err_out),
        .checksum_out     (checksum_out)
    );

    always #5 clock10mhz = ~clock10mhz;

    // Upstream queue model: registered output byte, updated on the dequeue edge.
    logic [7:0] mem [0:15];
    int         wrPtr;
    int         rdPtr;
    logic       lenOvrEn;
    logic [3:0] lenOvr;

    assign len_in = lenOvrEn ? lenOvr : 4'(wrPtr - rdPtr);

    always @(posedge clock10mhz) begin
        if (dequeue_out && (rdPtr != wrPtr)) begin
            data_in <= mem[rdPtr % 16];
            rdPtr   <= rdPtr + 1;
        end
    end

    // Scoreboard and bookkeeping.
    logic [7:0]  expQ[$];
    int          deqCycles[$];
    int          checks;
    int          errors;
    int          cyc;
    int          lastDeq;
    int          deqCount;
    logic        prevValid;
    logic        inFlight;
    logic        cntCheckPending;
    logic [15:0] expCount;
    logic [7:0]  expChk;
    logic [7:0]  expByte;

    typedef struct {
        logic [7:0]  data;
        int          readyDelay;
        logic [7:0]  chkEn;
        logic [15:0] count;
    } vec_t;

    vec_t vecs [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] chkModel(input logic [7:0] withFeature);
`ifdef QUEUE_DRAIN_CHECKSUM_EN
        return withFeature;
`else
        return 8'h00 & withFeature;
`endif
    endfunction

    // Monitor: latency, single-in-flight rule, and scoreboard compare on each handshake.
    always @(negedge clock10mhz) begin
        if (!reset) begin
            cyc++;
            if (cntCheckPending) begin
                check("byteCount", 32'(byte_count_out), 32'(expCount));
                check("checksum", 32'(checksum_out), 32'(chkModel(expChk)));
                cntCheckPending = 1'b0;
            end
            if (dequeue_out) begin
                check("deqWhileInFlight", 32'(inFlight), 32'(1'b0));
                inFlight = 1'b1;
                deqCount++;
                deqCycles.push_back(cyc);
                lastDeq = cyc;
            end
            if (valid_out && !prevValid) begin
                check("validLatency", 32'(cyc - lastDeq), 32'd2);
            end
            if (valid_out && ready_in) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedTransfer actual=0x%0h required=none", data_out);
                end else begin
                    expByte = expQ.pop_front();
                    check("dataOut", 32'(data_out), 32'(expByte));
                    expCount = expCount + 16'd1;
                    expChk   = expChk ^ expByte;
                    cntCheckPending = 1'b1;
                end
                inFlight = 1'b0;
            end
            prevValid = valid_out;
        end
    end

    task automatic assertReset();
        @(posedge clock10mhz);
        #2;
        reset = 1'b1;
        wrPtr = rdPtr;
        expQ.delete();
        deqCycles.delete();
        inFlight        = 1'b0;
        prevValid       = 1'b0;
        cntCheckPending = 1'b0;
        expCount        = 16'd0;
        expChk          = 8'h00;
        lastDeq         = -100;
        lenOvrEn        = 1'b0;
    endtask

    task automatic releaseReset();
        @(negedge clock10mhz);
        @(negedge clock10mhz);
        #1;
        reset    = 1'b0;
        cyc      = 0;
        deqCount = 0;
    endtask

    task automatic preload(input logic [7:0] b);
        mem[wrPtr % 16] = b;
        wrPtr++;
        expQ.push_back(b);
    endtask

    task automatic setReady(input logic v);
        @(posedge clock10mhz);
        #2;
        ready_in = v;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock10mhz);
    endtask

    task automatic waitValid(input string name, input int budget);
        int n = 0;
        while (!valid_out && n < budget) begin
            @(negedge clock10mhz);
            n++;
        end
        #1;
        if (!valid_out) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout actual=valid_low required=valid_high", name);
        end
    endtask

    task automatic waitDrained(input string name, input int budget);
        int n = 0;
        while ((expQ.size() != 0 || valid_out) && n < budget) begin
            @(negedge clock10mhz);
            n++;
        end
        @(negedge clock10mhz);
        #1;
        if (expQ.size() != 0 || valid_out) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout actual=%0d_pending required=0", name, expQ.size());
        end
    endtask

    // One table row: offer the byte, delay the downstream ready, let it transfer.
    task automatic applyStimulus(input vec_t v);
        @(posedge clock10mhz);
        #2;
        preload(v.data);
        waitValid("vecValid", 40);
        repeat (v.readyDelay) @(negedge clock10mhz);
        #1;
        check("vecHeld", 32'(data_out), 32'(v.data));
        setReady(1'b1);
        waitDrained("vecTransfer", 20);
        setReady(1'b0);
    endtask

    task automatic checkOutput(input vec_t v);
        @(negedge clock10mhz);
        #1;
        check("vecCount", 32'(byte_count_out), 32'(v.count));
        check("vecChecksum", 32'(checksum_out), 32'(chkModel(v.chkEn)));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        ready_in = 1'b0;
        lenOvrEn = 1'b0;
        lenOvr   = 4'd0;
        wrPtr    = 0;

        vecs[0] = '{data: 8'h0F, readyDelay: 0, chkEn: 8'h0F, count: 16'd1};
        vecs[1] = '{data: 8'hF0, readyDelay: 3, chkEn: 8'hFF, count: 16'd2};
        vecs[2] = '{data: 8'hAA, readyDelay: 7, chkEn: 8'h55, count: 16'd3};

        // Reset values.
        assertReset();
        #1;
        check("rstDequeue", 32'(dequeue_out), 32'd0);
        check("rstValid", 32'(valid_out), 32'd0);
        check("rstData", 32'(data_out), 32'd0);
        check("rstCount", 32'(byte_count_out), 32'd0);
        check("rstErr", 32'(protocol_err_out), 32'd0);
        check("rstChecksum", 32'(checksum_out), 32'd0);

        // Three preloaded bytes drained at the tick rate with ready held high.
        ready_in = 1'b1;
        preload(8'h11);
        preload(8'h22);
        preload(8'h33);
        releaseReset();
        waitCycles(45);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("deqCycle%0d", i),
                  32'((i < deqCycles.size()) ? deqCycles[i] : -1), 32'(10 * (i + 1)));
        end
        #1;
        check("burstCount", 32'(byte_count_out), 32'd3);
        waitCycles(30);
        check("noFourthDeq", 32'(deqCount), 32'd3);

        // Empty queue keeps the tick pending; first byte goes out on the next cycle.
        waitCycles(25);
        check("noDeqWhenEmpty", 32'(deqCount), 32'd3);
        @(posedge clock10mhz);
        #2;
        preload(8'h5C);
        @(negedge clock10mhz);
        #1;
        check("deqNotYet", 32'(dequeue_out), 32'd0);
        @(negedge clock10mhz);
        #1;
        check("deqFromPending", 32'(dequeue_out), 32'd1);
        waitDrained("pendingDrain", 20);
        check("pendingCount", 32'(byte_count_out), 32'd4);

        // Backpressure: byte held stable and no further dequeue while ready is low.
        setReady(1'b0);
        @(posedge clock10mhz);
        #2;
        preload(8'h7E);
        preload(8'h99);
        waitValid("bpValid", 30);
        begin
            int   base;
            logic stable;
            base   = deqCount;
            stable = 1'b1;
            repeat (20) begin
                @(negedge clock10mhz);
                #1;
                if (data_out !== 8'h7E || valid_out !== 1'b1) stable = 1'b0;
            end
            check("holdStable", 32'(stable), 32'd1);
            check("noDeqInHold", 32'(deqCount), 32'(base));
        end
        setReady(1'b1);
        waitDrained("bpDrain", 60);
        check("bpCount", 32'(byte_count_out), 32'd6);

        // Table-driven transfers with varying downstream delay and checksum.
        assertReset();
        ready_in = 1'b0;
        releaseReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        // Reset while a byte is held: it is dropped and draining restarts cleanly.
        @(posedge clock10mhz);
        #2;
        preload(8'hA5);
        waitValid("rstMidValid", 40);
        check("rstMidHeld", 32'(data_out), 32'h0000_00A5);
        assertReset();
        ready_in = 1'b1;
        #1;
        check("rstMidValidLow", 32'(valid_out), 32'd0);
        check("rstMidDataZero", 32'(data_out), 32'd0);
        check("rstMidCount", 32'(byte_count_out), 32'd0);
        check("rstMidChecksum", 32'(checksum_out), 32'd0);
        preload(8'h3C);
        releaseReset();
        begin
            int n = 0;
            while (deqCount == 0 && n < 30) begin
                @(negedge clock10mhz);
                n++;
            end
        end
        check("rstMidFirstDeq", 32'((deqCycles.size() > 0) ? deqCycles[0] : -1), 32'd10);
        waitDrained("rstMidDrain", 20);
        check("rstMidNewCount", 32'(byte_count_out), 32'd1);

        // Illegal occupancy for one cycle sets the sticky error until reset.
        assertReset();
        releaseReset();
        @(posedge clock10mhz);
        #2;
        check("errClear", 32'(protocol_err_out), 32'd0);
        lenOvr   = 4'd9;
        lenOvrEn = 1'b1;
        @(posedge clock10mhz);
        #2;
        lenOvrEn = 1'b0;
        @(negedge clock10mhz);
        #1;
        check("errSet", 32'(protocol_err_out), 32'd1);
        waitCycles(15);
        #1;
        check("errSticky", 32'(protocol_err_out), 32'd1);
        check("errNoDeq", 32'(deqCount), 32'd0);
        assertReset();
        #1;
        check("errCleared", 32'(protocol_err_out), 32'd0);
        releaseReset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/queue_drain_ctrl.md
Name: queue_drain_ctrl

Overview:
- Downstream consumer of the 8-entry byte queue in the 10 MHz domain.
- Watches the queue occupancy and issues single-cycle dequeue pulses at a programmable drain rate.
- Captures each dequeued byte and presents it to the next stage on a valid/ready handshake.
- Also keeps a transferred-byte counter and a sticky protocol-error flag.

Parameters:
- DATA_W, 8, byte width; matches the queue data path.
- LEN_W, 4, width of the queue occupancy input.
- QUEUE_DEPTH, 8, maximum legal occupancy value.
- TICK_DIV, 10, clock cycles per drain opportunity; legal range 1..1024; default gives 1 MHz at 10 MHz.
- CNT_W, 16, width of the transferred-byte counter.

Ports:
- clock10mhz  in  1  system clock, 10 MHz; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- len_in  in  LEN_W  queue occupancy, driven from queue len_out.
- data_in  in  DATA_W  queue output byte, driven from queue data_out.
- dequeue_out  out  1  one-cycle dequeue request to queue dequeue_in.
- data_out  out  DATA_W  captured byte for the downstream stage.
- valid_out  out  1  data_out holds a byte not yet accepted.
- ready_in  in  1  downstream can accept this cycle.
- byte_count_out  out  CNT_W  number of accepted transfers; wraps modulo 2^CNT_W.
- protocol_err_out  out  1  sticky; set when len_in > QUEUE_DEPTH.
- checksum_out  out  DATA_W  running XOR checksum (see Optional Feature).

Behaviour:
Reset (asynchronous):
- Outputs: dequeue_out=0, data_out=0, valid_out=0, byte_count_out=0, protocol_err_out=0, checksum_out=0.
- Internal: state=IDLE, tick counter=0, tick_pending=0.

Tick generator:
- Counter runs 0..TICK_DIV-1 and wraps.
- tick is high in the cycle the counter equals TICK_DIV-1.
- With TICK_DIV=1, tick is high every cycle.
- A tick sets tick_pending. Entering DEQ clears it. Ticks arriving while pending is already set are merged (no queuing of multiple ticks).

FSM states: IDLE, DEQ, CAPT, HOLD.
- IDLE: if (tick || tick_pending) and len_in != 0, go to DEQ. Otherwise stay in IDLE.
- DEQ: dequeue_out=1 for exactly this cycle, then go to CAPT. The queue registers its output byte on this edge.
- CAPT: at the clock edge ending this cycle, data_out<=data_in and valid_out<=1 take effect; go to HOLD.
- HOLD: valid_out stays 1 and data_out stays stable until valid_out && ready_in.
  - On the transfer edge: valid_out<=0, byte_count_out increments, go to IDLE.
- dequeue_out is asserted only in DEQ, never twice without an intervening transfer.
  - At most one byte is in flight, so the queue is never over-drained.

Latency:
- dequeue_out high in cycle N, so valid_out rises in cycle N+2.
- Minimum spacing between dequeues with ready_in held high is 4 cycles (DEQ, CAPT, HOLD, IDLE), or TICK_DIV cycles, whichever is larger.

Boundaries:
- len_in==0 in IDLE: no dequeue; tick_pending is retained.
- ready_in high with valid_out low: ignored.
- len_in > QUEUE_DEPTH in any cycle: protocol_err_out<=1 and stays set until reset; operation otherwise continues.
- byte_count_out wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-transfer: any held byte is discarded.

Optional Feature:
Macro QUEUE_DRAIN_CHECKSUM_EN.
- Defined: on every accepted transfer, checksum_out <= checksum_out ^ data_out.
- Undefined: checksum_out is a constant 0 and no checksum register is synthesised.

Decomposition:
- Shared package queue_pkg holds:
  - DATA_W, LEN_W, QUEUE_DEPTH constants.
  - typedef byte_t (logic [DATA_W-1:0]).
  - typedef len_t (logic [LEN_W-1:0]).
  - enum drain_state_t {IDLE, DEQ, CAPT, HOLD}.
- One sub-module, rate_tick_gen (parameter TICK_DIV; ports clock10mhz, reset, tick), is instantiated once.

Test Plan:
- Reset while valid_out=1 holding 8'hA5 -> next cycle all outputs 0, state IDLE, no dequeue_out until a new tick.
- TICK_DIV=10, queue preloaded 8'h11,8'h22,8'h33, ready_in=1 -> dequeue_out pulses 10 cycles apart; data_out sequence 11,22,33; each valid_out rises 2 cycles after its dequeue_out; byte_count_out=3; no 4th dequeue.
- len_in=0 for 25 cycles, then len_in=1 with 8'h5C -> exactly one dequeue_out in the cycle after len_in becomes non-zero (pending tick); data_out=8'h5C.
- ready_in=0 for 20 cycles after valid_out rises with 8'h7E -> data_out stable at 7E, no further dequeue_out; ready_in=1 -> one transfer, count +1.
- len_in forced to 4'd9 for one cycle -> protocol_err_out=1 and held until reset.
- With QUEUE_DRAIN_CHECKSUM_EN defined, transfer 8'h0F, 8'hF0, 8'hAA -> checksum_out=8'h55. Without the macro -> checksum_out=0 throughout.
